// File: rtl/codec_pkg.sv
// Shared types and constants for the codec frame scheduler: sample width,
// saturation limits and the FILL/FULL state encoding.
package codec_pkg;

  localparam int SAMPLE_W = 16;
  localparam int NUM_SRC  = 2;
  localparam int NUM_CH   = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/codec_frame_scheduler_if.sv
// Bundle of the source/codec-side signals of codec_frame_scheduler; the
// master side drives sources and the accept level, the slave side is the scheduler.
interface codec_frame_scheduler_if;
  import codec_pkg::*;

  logic        pcm_accept;
  logic [1:0]  mix_en;
  logic        src0_valid;
  logic        src1_valid;
  sample_t     src0_left;
  sample_t     src0_right;
  sample_t     src1_left;
  sample_t     src1_right;
  logic        src0_ready;
  logic        src1_ready;
  sample_t     pcm_left;
  sample_t     pcm_right;
  logic        frame_pulse;
  logic [7:0]  underrun_cnt;

  modport master (
    output pcm_accept, mix_en, src0_valid, src1_valid,
           src0_left, src0_right, src1_left, src1_right,
    input  src0_ready, src1_ready, pcm_left, pcm_right, frame_pulse, underrun_cnt
  );

  modport slave (
    input  pcm_accept, mix_en, src0_valid, src1_valid,
           src0_left, src0_right, src1_left, src1_right,
    output src0_ready, src1_ready, pcm_left, pcm_right, frame_pulse, underrun_cnt
  );

endinterface

// File: rtl/sat_add16.sv
// Signed 16-bit adder that clamps to SAT_MAX / SAT_MIN instead of wrapping.
module sat_add16
  import codec_pkg::*;
(
  input  sample_t i_a,
  input  sample_t i_b,
  output sample_t o_sum
);

  logic [SAMPLE_W:0] w_wide;

  assign w_wide = {i_a[SAMPLE_W-1], i_a} + {i_b[SAMPLE_W-1], i_b};

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    o_sum = w_wide[SAMPLE_W-1:0];
    if (w_wide[SAMPLE_W] != w_wide[SAMPLE_W-1]) begin
      o_sum = w_wide[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/codec_frame_scheduler.sv
// Collects one sample per enabled source each frame, mixes them with saturation
// and presents the result to the codec on each accept rising edge.
// Optional build macro UNDERRUN_CNT_EN enables the underrun frame counter.
module codec_frame_scheduler
  import codec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pcm_accept,
  input  logic       src0_valid,
  input  logic       src1_valid,
  input  sample_t    src0_left,
  input  sample_t    src0_right,
  input  sample_t    src1_left,
  input  sample_t    src1_right,
  output logic       src0_ready,
  output logic       src1_ready,
  input  logic [1:0] mix_en,
  output sample_t    pcm_left,
  output sample_t    pcm_right,
  output logic       frame_pulse,
  output logic [7:0] underrun_cnt
);

  state_t          r_state;
  logic            r_accept_d;
  logic [1:0]      r_cap;
  sample_t         r_samp [NUM_CH][NUM_SRC];
  sample_t         r_staged [NUM_CH];
  sample_t         r_held [NUM_CH];

  sample_t         w_in [NUM_CH][NUM_SRC];
  sample_t         w_mix [NUM_CH][NUM_SRC];
  sample_t         w_sum [NUM_CH];
  logic [1:0]      w_valid;
  logic [1:0]      w_ready;
  logic [1:0]      w_take;
  logic [1:0]      w_cap_now;
  logic            w_all_cap;
  logic            w_frame_pulse;

  assign w_in[0][0] = src0_left;
  assign w_in[1][0] = src0_right;
  assign w_in[0][1] = src1_left;
  assign w_in[1][1] = src1_right;
  assign w_valid    = {src1_valid, src0_valid};

  assign w_frame_pulse = pcm_accept & ~r_accept_d & ~reset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_ready[gi]   = (r_state == ST_FILL) & mix_en[gi] & ~r_cap[gi] & ~reset;
      assign w_take[gi]    = w_valid[gi] & w_ready[gi];
      assign w_cap_now[gi] = r_cap[gi] | w_take[gi];
      // A source completing on this edge feeds the mixer straight from its inputs.
      assign w_mix[0][gi]  = !mix_en[gi] ? '0 : (r_cap[gi] ? r_samp[0][gi] : w_in[0][gi]);
      assign w_mix[1][gi]  = !mix_en[gi] ? '0 : (r_cap[gi] ? r_samp[1][gi] : w_in[1][gi]);
    end
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      sat_add16 u_sat (
        .i_a   (w_mix[gi][0]),
        .i_b   (w_mix[gi][1]),
        .o_sum (w_sum[gi])
      );
    end
  endgenerate

  assign w_all_cap  = &(w_cap_now | ~mix_en);
  assign src0_ready = w_ready[0];
  assign src1_ready = w_ready[1];
  assign frame_pulse = w_frame_pulse;

  always_comb begin
    pcm_left  = r_held[0];
    pcm_right = r_held[1];
    if (w_frame_pulse) begin
      pcm_left  = (r_state == ST_FULL) ? r_staged[0] : '0;
      pcm_right = (r_state == ST_FULL) ? r_staged[1] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FILL;
      r_accept_d <= 1'b1;
      r_cap      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_staged[c] <= '0;
        r_held[c]   <= '0;
        for (int s = 0; s < NUM_SRC; s++) r_samp[c][s] <= '0;
      end
    end else begin
      r_accept_d <= pcm_accept;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (w_take[s]) begin
          r_cap[s]     <= 1'b1;
          r_samp[0][s] <= w_in[0][s];
          r_samp[1][s] <= w_in[1][s];
        end
      end
      case (r_state)
        ST_FILL: begin
          // Underrun: codec gets silence; partial captures survive into the next frame.
          if (w_frame_pulse) begin
            r_held[0] <= '0;
            r_held[1] <= '0;
          end else if (w_all_cap) begin
            r_staged[0] <= w_sum[0];
            r_staged[1] <= w_sum[1];
            r_state     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_frame_pulse) begin
            r_held[0] <= r_staged[0];
            r_held[1] <= r_staged[1];
            r_cap     <= '0;
            r_state   <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [7:0] r_underrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun <= '0;
    end else if (w_frame_pulse && (r_state == ST_FILL) && (r_underrun != 8'hFF)) begin
      r_underrun <= r_underrun + 8'd1;
    end
  end

  assign underrun_cnt = r_underrun;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_codec_frame_scheduler.sv
// Directed self-checking bench for codec_frame_scheduler; honours UNDERRUN_CNT_EN.
module tb_codec_frame_scheduler;
  import codec_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  codec_frame_scheduler_if bus ();

  codec_frame_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .pcm_accept   (bus.pcm_accept),
    .src0_valid   (bus.src0_valid),
    .src1_valid   (bus.src1_valid),
    .src0_left    (bus.src0_left),
    .src0_right   (bus.src0_right),
    .src1_left    (bus.src1_left),
    .src1_right   (bus.src1_right),
    .src0_ready   (bus.src0_ready),
    .src1_ready   (bus.src1_ready),
    .mix_en       (bus.mix_en),
    .pcm_left     (bus.pcm_left),
    .pcm_right    (bus.pcm_right),
    .frame_pulse  (bus.frame_pulse),
    .underrun_cnt (bus.underrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] exp_ur(input int n);
`ifdef UNDERRUN_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the cycle where accept has just risen.
  task automatic raise_accept();
    bus.pcm_accept = 1'b0;
    step();
    bus.pcm_accept = 1'b1;
    #1;
  endtask

  task automatic do_reset(input logic [1:0] en);
    bus.pcm_accept = 1'b1;
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    bus.mix_en     = en;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.mix_en = 2'b11;
    bus.src0_valid = 1'b1;
    bus.src1_valid = 1'b1;
    bus.pcm_accept = 1'b1;
    reset = 1'b1;
    step();
    #1;
    n_checks++;
    if (bus.src0_ready !== 1'b0 || bus.src1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: got %b%b want 00", bus.src1_ready, bus.src0_ready);
    end
    n_checks++;
    if (bus.pcm_left !== 16'sd0 || bus.pcm_right !== 16'sd0) begin
      n_errors++;
      $display("FAIL reset_pcm: got %0d/%0d want 0/0", bus.pcm_left, bus.pcm_right);
    end
    n_checks++;
    if (bus.underrun_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_underrun: got %0d want 0", bus.underrun_cnt);
    end
    raise_accept();
    n_checks++;
    if (bus.frame_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pulse_in_reset: got %b want 0", bus.frame_pulse);
    end
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    bus.mix_en = 2'b00;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus.frame_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_no_spurious_pulse: cycle %0d got %b want 0", i, bus.frame_pulse);
      end
      step();
    end
    raise_accept();
    n_checks++;
    if (bus.frame_pulse !== 1'b1 || bus.pcm_left !== 16'sd0 || bus.pcm_right !== 16'sd0) begin
      n_errors++;
      $display("FAIL reset_first_pulse: got pulse=%b pcm=%0d/%0d want 1 0/0",
               bus.frame_pulse, bus.pcm_left, bus.pcm_right);
    end
    step();
    n_checks++;
    if (bus.underrun_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_empty_mix_no_underrun: got %0d want 0", bus.underrun_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_source();
    do_reset(2'b01);
    bus.src0_left  = 16'sd1000;
    bus.src0_right = -16'sd1000;
    bus.src0_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.src0_ready !== 1'b1 || bus.src1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL single_ready_fill: got %b%b want 01", bus.src1_ready, bus.src0_ready);
    end
    step();
    bus.src0_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.src0_ready !== 1'b0 || bus.pcm_left !== 16'sd0) begin
      n_errors++;
      $display("FAIL single_full_hold: got ready=%b pcm_left=%0d want 0 0", bus.src0_ready, bus.pcm_left);
    end
    raise_accept();
    n_checks++;
    if (bus.frame_pulse !== 1'b1 || bus.pcm_left !== 16'sd1000 || bus.pcm_right !== -16'sd1000) begin
      n_errors++;
      $display("FAIL single_frame1: got pulse=%b pcm=%0d/%0d want 1 1000/-1000",
               bus.frame_pulse, bus.pcm_left, bus.pcm_right);
    end
    step();
    bus.src0_left  = 16'sd5;
    bus.src0_right = 16'sd7;
    bus.src0_valid = 1'b1;
    step();
    bus.src0_valid = 1'b0;
    step();
    n_checks++;
    if (bus.frame_pulse !== 1'b0 || bus.pcm_left !== 16'sd1000 || bus.pcm_right !== -16'sd1000) begin
      n_errors++;
      $display("FAIL single_held: got pulse=%b pcm=%0d/%0d want 0 1000/-1000",
               bus.frame_pulse, bus.pcm_left, bus.pcm_right);
    end
    raise_accept();
    n_checks++;
    if (bus.pcm_left !== 16'sd5 || bus.pcm_right !== 16'sd7) begin
      n_errors++;
      $display("FAIL single_frame2: got %0d/%0d want 5/7", bus.pcm_left, bus.pcm_right);
    end
    step();
    n_checks++;
    if (bus.underrun_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL single_underrun: got %0d want 0", bus.underrun_cnt);
    end
    $display("test_single_source done");
  endtask

  task automatic test_saturation();
    do_reset(2'b11);
    bus.src0_left  = 16'sd30000;
    bus.src0_right = 16'sd100;
    bus.src1_left  = 16'sd10000;
    bus.src1_right = -16'sd300;
    bus.src0_valid = 1'b1;
    bus.src1_valid = 1'b1;
    step();
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    raise_accept();
    n_checks++;
    if (bus.pcm_left !== 16'sh7FFF || bus.pcm_right !== -16'sd200) begin
      n_errors++;
      $display("FAIL sat_positive: got %0d/%0d want 32767/-200", bus.pcm_left, bus.pcm_right);
    end
    step();
    bus.src0_left  = -16'sd30000;
    bus.src0_right = 16'sh8000;
    bus.src1_left  = -16'sd10000;
    bus.src1_right = -16'sd1;
    bus.src0_valid = 1'b1;
    step();
    n_checks++;
    if (bus.src0_ready !== 1'b0 || bus.src1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_partial_ready: got %b%b want 10", bus.src1_ready, bus.src0_ready);
    end
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b1;
    step();
    bus.src1_valid = 1'b0;
    raise_accept();
    n_checks++;
    if (bus.pcm_left !== 16'sh8000 || bus.pcm_right !== 16'sh8000) begin
      n_errors++;
      $display("FAIL sat_negative: got %0d/%0d want -32768/-32768", bus.pcm_left, bus.pcm_right);
    end
    step();
    $display("test_saturation done");
  endtask

  task automatic test_underrun();
    do_reset(2'b11);
    bus.src0_left = 16'sd100;  bus.src0_right = 16'sd1;
    bus.src1_left = 16'sd200;  bus.src1_right = 16'sd2;
    bus.src0_valid = 1'b1;
    bus.src1_valid = 1'b1;
    step();
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    raise_accept();
    n_checks++;
    if (bus.pcm_left !== 16'sd300 || bus.pcm_right !== 16'sd3) begin
      n_errors++;
      $display("FAIL underrun_good_frame: got %0d/%0d want 300/3", bus.pcm_left, bus.pcm_right);
    end
    step();
    bus.src0_left = 16'sd111;
    bus.src0_right = 16'sd222;
    bus.src0_valid = 1'b1;
    step();
    bus.src0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      raise_accept();
      n_checks++;
      if (bus.pcm_left !== 16'sd0 || bus.pcm_right !== 16'sd0) begin
        n_errors++;
        $display("FAIL underrun_silence: frame %0d got %0d/%0d want 0/0", k, bus.pcm_left, bus.pcm_right);
      end
      step();
      n_checks++;
      if (bus.underrun_cnt !== exp_ur(k)) begin
        n_errors++;
        $display("FAIL underrun_count: frame %0d got %0d want %0d", k, bus.underrun_cnt, exp_ur(k));
      end
      n_checks++;
      if (bus.src0_ready !== 1'b0 || bus.src1_ready !== 1'b1 || bus.pcm_left !== 16'sd0) begin
        n_errors++;
        $display("FAIL underrun_partial_kept: frame %0d got ready=%b%b pcm_left=%0d want 10 0",
                 k, bus.src1_ready, bus.src0_ready, bus.pcm_left);
      end
    end
    bus.pcm_accept = 1'b0;
    step();
    bus.pcm_accept = 1'b1;
    bus.src1_left  = 16'sd1000;
    bus.src1_right = 16'sd2000;
    bus.src1_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.frame_pulse !== 1'b1 || bus.pcm_left !== 16'sd0 || bus.src1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL underrun_coincident: got pulse=%b pcm_left=%0d ready1=%b want 1 0 1",
               bus.frame_pulse, bus.pcm_left, bus.src1_ready);
    end
    step();
    bus.src1_valid = 1'b0;
    n_checks++;
    if (bus.underrun_cnt !== exp_ur(4)) begin
      n_errors++;
      $display("FAIL underrun_coincident_count: got %0d want %0d", bus.underrun_cnt, exp_ur(4));
    end
    step();
    raise_accept();
    n_checks++;
    if (bus.pcm_left !== 16'sd1111 || bus.pcm_right !== 16'sd2222) begin
      n_errors++;
      $display("FAIL underrun_kept_capture: got %0d/%0d want 1111/2222", bus.pcm_left, bus.pcm_right);
    end
    step();
    for (int k = 0; k < 300; k++) begin
      bus.pcm_accept = 1'b0;
      step();
      bus.pcm_accept = 1'b1;
      step();
    end
    n_checks++;
    if (bus.underrun_cnt !== exp_ur(304)) begin
      n_errors++;
      $display("FAIL underrun_saturate: got %0d want %0d", bus.underrun_cnt, exp_ur(304));
    end
    $display("test_underrun done");
  endtask

  task automatic test_mix_change();
    do_reset(2'b00);
    step();
    raise_accept();
    n_checks++;
    if (bus.frame_pulse !== 1'b1 || bus.pcm_left !== 16'sd0 || bus.pcm_right !== 16'sd0) begin
      n_errors++;
      $display("FAIL mix_none: got pulse=%b pcm=%0d/%0d want 1 0/0", bus.frame_pulse, bus.pcm_left, bus.pcm_right);
    end
    step();
    bus.mix_en = 2'b11;
    bus.src0_left = 16'sd50;
    bus.src0_right = 16'sd60;
    bus.src0_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.src1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mix_src1_ready_on: got %b want 1", bus.src1_ready);
    end
    step();
    bus.src0_valid = 1'b0;
    bus.mix_en = 2'b01;
    #1;
    n_checks++;
    if (bus.src0_ready !== 1'b0 || bus.src1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mix_src1_ready_off: got %b%b want 00", bus.src1_ready, bus.src0_ready);
    end
    step();
    raise_accept();
    n_checks++;
    if (bus.pcm_left !== 16'sd50 || bus.pcm_right !== 16'sd60) begin
      n_errors++;
      $display("FAIL mix_change_frame: got %0d/%0d want 50/60", bus.pcm_left, bus.pcm_right);
    end
    step();
    n_checks++;
    if (bus.underrun_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL mix_underrun: got %0d want 0", bus.underrun_cnt);
    end
    $display("test_mix_change done");
  endtask

  task automatic test_random_frames();
    sample_t q_l[$];
    sample_t q_r[$];
    sample_t prev_l;
    sample_t prev_r;
    logic [15:0] next_val;
    int gap;
    logic exp_pulse;
    do_reset(2'b01);
    step();
    next_val = 16'd1;
    prev_l = bus.pcm_left;
    prev_r = bus.pcm_right;
    for (int f = 0; f < 1000; f++) begin
      gap = int'($urandom_range(1, 4));
      for (int c = 0; c <= gap + 1; c++) begin
        bus.pcm_accept = (c == gap) ? 1'b0 : 1'b1;
        bus.src0_valid = ($urandom_range(0, 2) != 0);
        bus.src0_left  = sample_t'(next_val);
        bus.src0_right = sample_t'(~next_val);
        exp_pulse = (c == gap + 1);
        #1;
        n_checks++;
        if (bus.frame_pulse !== exp_pulse) begin
          n_errors++;
          $display("FAIL rand_pulse: frame %0d cycle %0d got %b want %b", f, c, bus.frame_pulse, exp_pulse);
        end
        n_checks++;
        if (bus.src0_ready !== (q_l.size() == 0)) begin
          n_errors++;
          $display("FAIL rand_ready: frame %0d got %b want %b", f, bus.src0_ready, q_l.size() == 0);
        end
        if (exp_pulse) begin
          n_checks++;
          if (q_l.size() > 0) begin
            if (bus.pcm_left !== q_l[0] || bus.pcm_right !== q_r[0]) begin
              n_errors++;
              $display("FAIL rand_sample: frame %0d got %0d/%0d want %0d/%0d",
                       f, bus.pcm_left, bus.pcm_right, q_l[0], q_r[0]);
            end
            void'(q_l.pop_front());
            void'(q_r.pop_front());
          end else if (bus.pcm_left !== 16'sd0 || bus.pcm_right !== 16'sd0) begin
            n_errors++;
            $display("FAIL rand_underrun: frame %0d got %0d/%0d want 0/0", f, bus.pcm_left, bus.pcm_right);
          end
        end else begin
          n_checks++;
          if (bus.pcm_left !== prev_l || bus.pcm_right !== prev_r) begin
            n_errors++;
            $display("FAIL rand_hold: frame %0d got %0d/%0d want %0d/%0d",
                     f, bus.pcm_left, bus.pcm_right, prev_l, prev_r);
          end
        end
        if (bus.src0_valid && bus.src0_ready) begin
          q_l.push_back(bus.src0_left);
          q_r.push_back(bus.src0_right);
          next_val = next_val + 16'd1;
        end
        prev_l = bus.pcm_left;
        prev_r = bus.pcm_right;
        @(posedge clk);
        #1;
      end
    end
    bus.src0_valid = 1'b0;
    $display("test_random_frames done: %0d samples accepted", next_val - 16'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.pcm_accept = 1'b1;
    bus.mix_en     = 2'b00;
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    bus.src0_left  = '0;
    bus.src0_right = '0;
    bus.src1_left  = '0;
    bus.src1_right = '0;
    test_reset();
    test_single_source();
    test_saturation();
    test_underrun();
    test_mix_change();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/codec_frame_scheduler.md
CODEC_FRAME_SCHEDULER -- requirements
Module: codec_frame_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, sole clock.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port pcm_accept, input, 1, codec frame-accept level (PCM_Playback_Accept).
REQ-004 SHALL have port src0_valid / src1_valid, input, 1 each, source sample available.
REQ-005 SHALL have port src0_left, src0_right, src1_left, src1_right, input, 16 each, signed samples.
REQ-006 SHALL have port src0_ready / src1_ready, output, 1 each, sample taken when valid&ready at clk edge.
REQ-007 SHALL have port mix_en, input, 2, per-source enable; bit0=src0, bit1=src1.
REQ-008 SHALL have port pcm_left / pcm_right, output, 16 each, to codec playback inputs.
REQ-009 SHALL have port frame_pulse, output, 1, one-cycle pulse on accept rising edge.
REQ-010 SHALL have port underrun_cnt, output, 8, frames with no staged sample.

Function
REQ-011 SHALL register accept_d <= pcm_accept; frame_pulse = pcm_accept & ~accept_d.
REQ-012 SHALL implement states FILL (collecting) and FULL (staged sample ready).
REQ-013 In FILL, srcN_ready SHALL be high iff mix_en[N] and source N not yet captured this frame; ready low in FULL.
REQ-014 Captured samples SHALL be held per source; disabled sources contribute 0.
REQ-015 FILL->FULL SHALL occur on the edge where all enabled sources are captured; staged = saturating sum per channel (clamp to 16'sh7FFF / 16'sh8000).
REQ-016 mix_en==0 in FILL SHALL go FULL next edge with staged = 0.
REQ-017 pcm_left/right SHALL equal staged when frame_pulse && state==FULL, else held; outputs change only in frame_pulse cycles.
REQ-018 On frame_pulse edge in FULL: held <= staged, capture flags cleared, state -> FILL.
REQ-019 On frame_pulse edge in FILL (underrun): pcm outputs show 0 that cycle, held <= 0, partial captures kept, state stays FILL, underrun_cnt +1 saturating at 255.
REQ-020 A capture coinciding with frame_pulse in FILL SHALL be kept but SHALL NOT avoid the underrun.
REQ-021 mix_en changes SHALL take effect for the next capture decision; already-captured samples are kept.

Reset
REQ-022 Reset SHALL set state FILL, accept_d=1 (no spurious pulse), held/staged/captures=0, underrun_cnt=0, ready=0 that cycle.
REQ-023 Reset mid-FILL or mid-FULL SHALL discard all staged and captured data.

Configuration
REQ-024 With UNDERRUN_CNT_EN defined, underrun_cnt SHALL behave per REQ-019; without it the counter is not built and underrun_cnt is tied 0.

Structure
REQ-025 State encoding, sample width (16) and saturation limits SHALL live in shared package codec_pkg.
REQ-026 Saturating 16-bit signed adder SHALL be sub-module sat_add16 (two instances, left/right).

Verification
REQ-027 mix_en=01, src0 L=1000 R=-1000 valid before accept rise -> next frame_pulse pcm=1000/-1000, held until following pulse.
REQ-028 mix_en=11, src0 L=30000, src1 L=10000 -> pcm_left=32767; src0 L=-30000, src1 L=-10000 -> -32768.
REQ-029 mix_en=11, src1 never valid -> each pulse outputs 0, underrun_cnt 1,2,3...; 300 frames -> 255 (0 without UNDERRUN_CNT_EN).
REQ-030 Reset asserted with pcm_accept=1 -> no frame_pulse after release until accept falls and rises again.
REQ-031 Random valid gaps, 1000 frames -> pcm outputs never change outside frame_pulse cycles; each accepted sample appears exactly once.
